// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding,
// requester index constants, default byte width and a round-robin helper.
package uart_arb_pkg;

    localparam int ARB_DATA_W = 8;

    localparam int REQ_WATCH = 0;
    localparam int REQ_DHT   = 1;
    localparam int REQ_SR04  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // Index that follows idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_arb_rr_picker.sv
// Combinational round-robin picker: returns the first asserted entry of
// valid_i at or after ptr_i (wrapping), plus a flag saying any entry is set.
// ptr_i is expected to be below N.
module rr_picker #(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    valid_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    logic [ID_W-1:0] cand [N];
    logic [N-1:0]    hit;

    // cand[k] is the index k places after the pointer; hit[k] says it is valid.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign cand[gi] = ID_W'(((int'(ptr_i) + gi) >= N) ? (int'(ptr_i) + gi - N)
                                                          : (int'(ptr_i) + gi));
        assign hit[gi]  = valid_i[cand[gi]];
    end

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        idx_o = '0;
        any_o = |hit;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter that shares one UART TX serializer
// between several byte sources. A winning source keeps the line until the
// byte it flagged as last has finished on the wire.
// Optional build macro UART_ARB_TIMEOUT_EN: releases a locked message whose
// source stays silent for TIMEOUT_CYC cycles between bytes and raises a
// sticky timeout_flag. Without it, timeout_flag is constant 0.
import uart_arb_pkg::*;

module uart_tx_arbiter #(
    parameter int N_REQ       = 3,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int TIMEOUT_CYC = 1_000_000,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    grant_valid,
    output logic [ID_W-1:0]         grant_id,
    output logic                    timeout_flag
);

    localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);

    arb_state_e        state_q;
    logic              grant_valid_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   ptr_q;
    logic [N_REQ-1:0]  req_ready_q;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              last_q;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [ID_W-1:0]   ptr_d;

    // Requests from the current owner only; everyone else is ignored while locked.
    assign sel_valid = req_valid[grant_id_q];
    assign sel_last  = req_last[grant_id_q];
    assign sel_data  = req_data[grant_id_q*DATA_W +: DATA_W];

    // The owner that just finished gets the lowest priority next round.
    assign ptr_d = ID_W'(rr_next(int'(grant_id_q), N_REQ));

    rr_picker #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_flag_q;
`endif

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            ptr_q         <= '0;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            last_q        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q          <= '0;
            timeout_flag_q <= 1'b0;
`endif
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    if (pick_any) begin
                        grant_valid_q <= 1'b1;
                        grant_id_q    <= pick_idx;
                        state_q       <= GRANT;
                    end
                end
                GRANT: begin
                    if (sel_valid && !tx_busy) begin
                        req_ready_q <= REQ_ONE << grant_id_q;
                        tx_start_q  <= 1'b1;
                        tx_data_q   <= sel_data;
                        last_q      <= sel_last;
                        state_q     <= ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_q       <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Saturate while the owner still has a byte pending behind tx_busy.
                        if (!sel_valid) begin
                            grant_valid_q  <= 1'b0;
                            timeout_flag_q <= 1'b1;
                            ptr_q          <= ptr_d;
                            cnt_q          <= '0;
                            state_q        <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        if (last_q) begin
                            grant_valid_q <= 1'b0;
                            ptr_q         <= ptr_d;
                            state_q       <= IDLE;
                        end else begin
                            state_q <= GRANT;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_flag = timeout_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule
